// File: rtl/ps2_host_sequencer_if.sv
// Bus bundle between the PS/2 host sequencer and the receiver, transmitter and data consumers.
interface ps2_host_sequencer_if;
  logic        MOUSE_MODE;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_done;
  logic        tx_error;
  logic [23:0] mouse_pkt;
  logic        mouse_pkt_valid;
  logic [7:0]  key_data;
  logic        key_valid;
  logic        ready;
  logic        init_fail;

  // Sequencer side.
  modport master (
    input  MOUSE_MODE, rx_data, rx_valid, tx_done, tx_error,
    output tx_data, tx_send, mouse_pkt, mouse_pkt_valid, key_data, key_valid, ready, init_fail
  );

  // PHY / consumer side.
  modport slave (
    output MOUSE_MODE, rx_data, rx_valid, tx_done, tx_error,
    input  tx_data, tx_send, mouse_pkt, mouse_pkt_valid, key_data, key_valid, ready, init_fail
  );
endinterface

// File: rtl/ps2_host_sequencer.sv
// PS/2 host init sequencer (reset / BAT / ID / enable) with keyboard and mouse streaming.
// Optional macro PS2_MOUSE_SYNC_CHECK_EN: drop mouse bytes at packet start whose bit 3 is clear.
module ps2_host_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 25000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic                  CLOCK50,
  input logic                  reset,
  ps2_host_sequencer_if.master bus
);

  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [3:0] {
    IDLE, SEND_RST, WAIT_ACK, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, STREAM, FAIL
  } state_t;

  state_t        state_q, state_d, nxt_state;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d;
  logic          mode_q, mode_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_send_q, tx_send_d;
  logic [23:0]   pkt_q, pkt_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic [7:0]    key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          go, retry_ev, wait_st, mode_chg, drop;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    mode_d      = bus.MOUSE_MODE;
    tx_data_d   = tx_data_q;
    tx_send_d   = 1'b0;
    pkt_d       = pkt_q;
    pkt_valid_d = 1'b0;
    key_d       = key_q;
    key_valid_d = 1'b0;
    nxt_state   = state_q;
    go          = 1'b0;
    retry_ev    = 1'b0;
    drop        = 1'b0;
`ifdef PS2_MOUSE_SYNC_CHECK_EN
    drop        = (cnt_q == 2'd0) && !bus.rx_data[3];
`endif
    wait_st  = (state_q == WAIT_ACK) || (state_q == WAIT_BAT) ||
               (state_q == WAIT_ID)  || (state_q == WAIT_ACK2);
    mode_chg = (bus.MOUSE_MODE != mode_q) && (state_q != FAIL);

    if (wait_st) tmo_d = tmo_q + TW'(1);

    // A mode change restarts init and overrides whatever the current state would do.
    if (mode_chg) begin
      go        = 1'b1;
      nxt_state = SEND_RST;
      retry_d   = '0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          go        = 1'b1;
          nxt_state = SEND_RST;
        end
        SEND_RST, SEND_EN: begin
          if (bus.tx_done) begin
            go        = 1'b1;
            nxt_state = (state_q == SEND_RST) ? WAIT_ACK : WAIT_ACK2;
          end else if (bus.tx_error) begin
            retry_ev = 1'b1;
          end
        end
        WAIT_ACK, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
          if (bus.rx_valid) begin
            tmo_d = '0;
            go    = 1'b1;
            if (state_q == WAIT_ACK && bus.rx_data == 8'hFA)
              nxt_state = WAIT_BAT;
            else if (state_q == WAIT_BAT && bus.rx_data == 8'hAA)
              nxt_state = bus.MOUSE_MODE ? WAIT_ID : STREAM;
            else if (state_q == WAIT_ID && bus.rx_data == 8'h00)
              nxt_state = SEND_EN;
            else if (state_q == WAIT_ACK2 && bus.rx_data == 8'hFA)
              nxt_state = STREAM;
            else begin
              go       = 1'b0;
              retry_ev = 1'b1;
            end
          end else if (tmo_q == TMO_LAST) begin
            retry_ev = 1'b1;
          end
        end
        STREAM: begin
          if (bus.rx_valid) begin
            tmo_d = '0;
            if (!bus.MOUSE_MODE) begin
              key_d       = bus.rx_data;
              key_valid_d = 1'b1;
            end else if (!drop) begin
              case (cnt_q)
                2'd0: begin
                  b0_d  = bus.rx_data;
                  cnt_d = 2'd1;
                end
                2'd1: begin
                  b1_d  = bus.rx_data;
                  cnt_d = 2'd2;
                end
                default: begin
                  pkt_d       = {bus.rx_data, b1_q, b0_q};
                  pkt_valid_d = 1'b1;
                  cnt_d       = 2'd0;
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end

    if (retry_ev) begin
      go = 1'b1;
      if (retry_q == RETRY_LAST) begin
        nxt_state = FAIL;
      end else begin
        nxt_state = SEND_RST;
        retry_d   = retry_q + RW'(1);
      end
    end

    // Every transition (including SEND_RST re-entry) counts as a state entry.
    if (go) begin
      state_d = nxt_state;
      tmo_d   = '0;
      if (nxt_state == SEND_RST) begin
        tx_send_d = 1'b1;
        tx_data_d = 8'hFF;
      end else if (nxt_state == SEND_EN) begin
        tx_send_d = 1'b1;
        tx_data_d = 8'hF4;
      end else if (nxt_state == STREAM) begin
        retry_d = '0;
        cnt_d   = '0;
      end
    end

    ready_d = (state_d == STREAM);
    fail_d  = (state_d == FAIL);
  end

  always_ff @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      retry_q     <= '0;
      cnt_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      mode_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      mode_q      <= mode_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      pkt_q       <= pkt_d;
      pkt_valid_q <= pkt_valid_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.tx_data         = tx_data_q;
  assign bus.tx_send         = tx_send_q;
  assign bus.mouse_pkt       = pkt_q;
  assign bus.mouse_pkt_valid = pkt_valid_q;
  assign bus.key_data        = key_q;
  assign bus.key_valid       = key_valid_q;
  assign bus.ready           = ready_q;
  assign bus.init_fail       = fail_q;

endmodule

// File: tb/tb_ps2_host_sequencer.sv
// Scoreboard bench for ps2_host_sequencer: randomized init/stream traffic vs. a packet-level model.
`timescale 1ns/1ps
module tb_ps2_host_sequencer;
  localparam int unsigned TMO     = 100;
  localparam int unsigned RETRIES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_sequencer_if bus ();

  ps2_host_sequencer #(.ACK_TIMEOUT(TMO), .MAX_RETRY(RETRIES)) dut (
    .CLOCK50 (clk),
    .reset   (rst),
    .bus     (bus.master)
  );

  typedef struct {
    logic [23:0] data;
    int unsigned due;
  } exp_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned tx_seen  = 0;
  int unsigned tx_target = 0;
  int unsigned last_tx_cyc = 0;
  logic [7:0]  exp_tx[$];
  exp_t        exp_key[$];
  exp_t        exp_pkt[$];
  logic [7:0]  pend[$];
  logic [23:0] model_pkt = '0;
  logic [7:0]  model_key = '0;
  bit          sync_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.tx_send) begin
        tx_seen++;
        last_tx_cyc = cyc;
        check("tx_send_outside_init", 32'({bus.ready, bus.init_fail}), 32'd0);
        if (exp_tx.size() == 0) check("unexpected_tx_send", 32'(bus.tx_send), 32'd0);
        else check("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
      end
      if (bus.key_valid) begin
        check("key_valid_outside_stream", 32'(bus.ready), 32'd1);
        if (exp_key.size() == 0) check("unexpected_key_valid", 32'(bus.key_valid), 32'd0);
        else begin
          e = exp_key.pop_front();
          check("key_data", 32'(bus.key_data), 32'(e.data));
          check("key_latency", cyc, e.due);
        end
      end
      if (bus.mouse_pkt_valid) begin
        check("pkt_valid_outside_stream", 32'(bus.ready), 32'd1);
        if (exp_pkt.size() == 0) check("unexpected_pkt_valid", 32'(bus.mouse_pkt_valid), 32'd0);
        else begin
          e = exp_pkt.pop_front();
          check("mouse_pkt", 32'(bus.mouse_pkt), 32'(e.data));
          check("pkt_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic gap();
    ticks($urandom_range(0, 4));
  endtask

  task automatic push_tx(input logic [7:0] b);
    exp_tx.push_back(b);
    tx_target++;
  endtask

  task automatic wait_tx(input string name);
    int unsigned n = 0;
    while (tx_seen < tx_target && n < 400) begin
      tick();
      n++;
    end
    if (tx_seen < tx_target) check({name, "_timeout"}, tx_seen, tx_target);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_done(output int unsigned at);
    ticks($urandom_range(0, 3));
    at = cyc + 1;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic pulse_err();
    ticks($urandom_range(0, 3));
    bus.tx_error = 1'b1;
    tick();
    bus.tx_error = 1'b0;
  endtask

  task automatic do_reset(input bit mode);
    ticks(3);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    check("key_queue_drained", 32'(exp_key.size()), 32'd0);
    check("pkt_queue_drained", 32'(exp_pkt.size()), 32'd0);
    rst = 1'b1;
    bus.MOUSE_MODE = mode;
    bus.rx_valid = 1'b0;
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;
    exp_tx.delete();
    pend.delete();
    model_pkt = '0;
    model_key = '0;
    tx_target = tx_seen;
    ticks(3);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_send", 32'(bus.tx_send), 32'd0);
    check("rst_mouse_pkt", 32'(bus.mouse_pkt), 32'd0);
    check("rst_pkt_valid", 32'(bus.mouse_pkt_valid), 32'd0);
    check("rst_key_data", 32'(bus.key_data), 32'd0);
    check("rst_key_valid", 32'(bus.key_valid), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_init_fail", 32'(bus.init_fail), 32'd0);
    push_tx(8'hFF);
    rst = 1'b0;
  endtask

  task automatic kb_init();
    int unsigned d;
    wait_tx("kb_rst_send");
    pulse_done(d);
    gap(); send_rx(8'hFA);
    gap(); send_rx(8'hAA);
    tick();
    check("kb_ready", 32'(bus.ready), 32'd1);
  endtask

  task automatic kb_retry_init();
    int unsigned d;
    wait_tx("kb_first_send");
    push_tx(8'hFF);
    pulse_err();
    wait_tx("kb_send_after_tx_error");
    pulse_done(d);
    gap();
    push_tx(8'hFF);
    send_rx(8'hFE);
    wait_tx("kb_send_after_resend");
    check("ready_low_during_retry", 32'(bus.ready), 32'd0);
    pulse_done(d);
    gap(); send_rx(8'hFA);
    gap(); send_rx(8'hAA);
    tick();
    check("kb_retry_ready", 32'(bus.ready), 32'd1);
    check("kb_retry_no_fail", 32'(bus.init_fail), 32'd0);
  endtask

  task automatic mouse_init();
    int unsigned d;
    wait_tx("ms_rst_send");
    pulse_done(d);
    gap(); send_rx(8'hFA);
    gap(); send_rx(8'hAA);
    gap();
    check("ms_ready_low_in_id", 32'(bus.ready), 32'd0);
    push_tx(8'hF4);
    send_rx(8'h00);
    wait_tx("ms_en_send");
    pulse_done(d);
    gap(); send_rx(8'hFA);
    tick();
    check("ms_ready", 32'(bus.ready), 32'd1);
  endtask

  task automatic key_byte(input logic [7:0] b);
    exp_key.push_back('{data: {16'h0, b}, due: cyc + 1});
    model_key = b;
    send_rx(b);
  endtask

  task automatic mouse_byte(input logic [7:0] b);
    if (!(sync_en && pend.size() == 0 && !b[3])) begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        model_pkt = {pend[2], pend[1], pend[0]};
        exp_pkt.push_back('{data: model_pkt, due: cyc + 1});
        pend.delete();
      end
    end
    send_rx(b);
  endtask

  task automatic kb_stream(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      key_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) gap();
    end
    ticks(2);
    check("key_data_hold", 32'(bus.key_data), 32'(model_key));
  endtask

  task automatic mouse_stream(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      mouse_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) gap();
    end
    ticks(2);
    check("mouse_pkt_hold", 32'(bus.mouse_pkt), 32'(model_pkt));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d;
    int unsigned start;
`ifdef PS2_MOUSE_SYNC_CHECK_EN
    sync_en = 1'b1;
`else
    sync_en = 1'b0;
`endif
    bus.MOUSE_MODE = 1'b0;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;
    bus.tx_done    = 1'b0;
    bus.tx_error   = 1'b0;
    ticks(2);

    do_reset(1'b0);
    kb_init();
    key_byte(8'h1C);
    kb_stream(12);

    do_reset(1'b0);
    kb_retry_init();
    kb_stream(4);

    do_reset(1'b1);
    mouse_init();
    mouse_byte(8'h09); mouse_byte(8'h05); mouse_byte(8'hFB);
    ticks(2);
    check("pkt_directed", 32'(bus.mouse_pkt), 32'h00FB0509);
    mouse_byte(8'h01); mouse_byte(8'h08); mouse_byte(8'h02); mouse_byte(8'h03);
    mouse_stream(30);

    // Mode switch 1->0 with a partial packet pending.
    mouse_byte(8'h08);
    tick();
    bus.MOUSE_MODE = 1'b0;
    pend.delete();
    push_tx(8'hFF);
    start = cyc;
    ticks(3);
    check("switch_tx_sent", tx_seen, tx_target);
    check("switch_tx_within_2", 32'((last_tx_cyc - start) <= 2), 32'd1);
    check("switch_ready_low", 32'(bus.ready), 32'd0);
    kb_init();
    kb_stream(6);

    bus.MOUSE_MODE = 1'b1;
    pend.delete();
    push_tx(8'hFF);
    mouse_init();
    mouse_stream(18);

    // Reset with a partial packet, then reset mid-transmission.
    mouse_byte(8'h18); mouse_byte(8'h20);
    do_reset(1'b1);
    wait_tx("mid_tx_send");
    do_reset(1'b1);
    mouse_init();
    mouse_stream(15);

    // Silent device: timeouts exhaust the retries.
    do_reset(1'($urandom_range(0, 1)));
    for (int unsigned r = 0; r < RETRIES; r++) begin
      wait_tx("silent_send");
      pulse_done(d);
      if (r < RETRIES - 1) begin
        push_tx(8'hFF);
        wait_tx("silent_retry");
        check("timeout_cycles", last_tx_cyc - d, TMO);
      end
    end
    ticks(TMO + 5);
    check("fail_init_fail", 32'(bus.init_fail), 32'd1);
    check("fail_ready", 32'(bus.ready), 32'd0);
    send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
    bus.MOUSE_MODE = ~bus.MOUSE_MODE;
    ticks(300);
    check("fail_sticky", 32'(bus.init_fail), 32'd1);
    check("fail_no_tx", tx_seen, tx_target);

    do_reset(1'b0);
    kb_init();
    kb_stream(5);
    ticks(3);
    check("final_tx_drained", 32'(exp_tx.size()), 32'd0);
    check("final_key_drained", 32'(exp_key.size()), 32'd0);
    check("final_pkt_drained", 32'(exp_pkt.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
